// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the control unit and its output decoder.
//   - opcode constants (ir_out[15:12])
//   - FSM state encoding (4-bit enum)
//   - ALU flag bit indices within latch_flags
//   - jump condition codes (ir_out[9:8])
//   - ctrl_t: one bundle carrying every control strobe and select
//   - cond_taken(): jump condition evaluation against the flag latch
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_JCC = 4'h5;
  localparam logic [3:0] OP_HLT = 4'h7;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  localparam logic [1:0] COND_Z  = 2'b00;
  localparam logic [1:0] COND_C  = 2'b01;
  localparam logic [1:0] COND_N  = 2'b10;
  localparam logic [1:0] COND_AL = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH_HI = 4'd0,
    S_FETCH_LO = 4'd1,
    S_DECODE   = 4'd2,
    S_ALU_EX   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MOV_EX   = 4'd5,
    S_ADDR_HI  = 4'd6,
    S_ADDR_LO  = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_JMP_EX   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       reg_load;
    logic       reg_enable;
    logic [1:0] reg_in_regselect;
    logic [1:0] reg_out_regselect;
    logic [1:0] reg_alu_regselect;
    logic [3:0] alu_operation;
    logic       latch_grab;
    logic       latch_store;
    logic       mar_high;
    logic       mar_low;
    logic       ir_high;
    logic       ir_low;
    logic       jr_high;
    logic       jr_low;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic       halted;
  } ctrl_t;

  function automatic logic cond_taken(input logic [1:0] cond, input logic [2:0] flags);
    logic taken;
    case (cond)
      COND_Z:  taken = flags[FLAG_Z];
      COND_C:  taken = flags[FLAG_C];
      COND_N:  taken = flags[FLAG_N];
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: purely combinational output decode for the control unit.
// Every strobe and select is a function of the current state and the
// instruction word; latch_flags only matters in S_JMP_EX, where it is
// sampled to decide pc_load.
//   state       in   current FSM state
//   ir_out      in   instruction word (opcode, rd, rs/cond, ALU op)
//   latch_flags in   ALU flags {N, C, Z}
//   ctrl        out  decoded control bundle (all zero unless named)
import cpu_pkg::*;

module cu_decode (
  input  state_t      state,
  input  logic [15:0] ir_out,
  input  logic [2:0]  latch_flags,
  output ctrl_t       ctrl
);

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] alu_op;
  logic       unused_ir;

  assign opcode    = ir_out[15:12];
  assign rd        = ir_out[11:10];
  assign rs        = ir_out[9:8];
  assign alu_op    = ir_out[7:4];
  assign unused_ir = ^ir_out[3:0];

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH_HI: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_high  = 1'b1;
        ctrl.pc_inc   = 1'b1;
      end
      S_FETCH_LO: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_low   = 1'b1;
        ctrl.pc_inc   = 1'b1;
      end
      S_ALU_EX: begin
        ctrl.alu_operation     = alu_op;
        ctrl.reg_alu_regselect = rs;
        ctrl.latch_grab        = 1'b1;
      end
      S_ALU_WB: begin
        ctrl.latch_store      = 1'b1;
        ctrl.reg_load         = 1'b1;
        ctrl.reg_in_regselect = rd;
      end
      S_MOV_EX: begin
        ctrl.reg_enable        = 1'b1;
        ctrl.reg_out_regselect = rs;
        ctrl.reg_load          = 1'b1;
        ctrl.reg_in_regselect  = rd;
      end
      // Address bytes land in JR for jumps, in MAR for loads and stores.
      S_ADDR_HI: begin
        ctrl.mem_read = 1'b1;
        ctrl.pc_inc   = 1'b1;
        ctrl.jr_high  = (opcode == OP_JCC);
        ctrl.mar_high = (opcode != OP_JCC);
      end
      S_ADDR_LO: begin
        ctrl.mem_read = 1'b1;
        ctrl.pc_inc   = 1'b1;
        ctrl.jr_low   = (opcode == OP_JCC);
        ctrl.mar_low  = (opcode != OP_JCC);
      end
      S_MEM_RD: begin
        ctrl.addr_sel         = 1'b1;
        ctrl.mem_read         = 1'b1;
        ctrl.reg_load         = 1'b1;
        ctrl.reg_in_regselect = rd;
      end
      // The register file drives the bus; memory only receives.
      S_MEM_WR: begin
        ctrl.addr_sel          = 1'b1;
        ctrl.mem_write         = 1'b1;
        ctrl.reg_enable        = 1'b1;
        ctrl.reg_out_regselect = rs;
      end
      // Not taken needs no action: PC already stepped past both address bytes.
      S_JMP_EX: begin
        ctrl.pc_load = cond_taken(rs, latch_flags);
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for a 16-bit CPU.
// The state register is the only storage; every output is a Moore decode
// of state and ir_out (see cu_decode), forced to zero while reset is high.
// Handshake note: there is no valid/ready flow here; each state lasts
// exactly one clock and the datapath acts on the strobes of that cycle.
//   clock              in   rising-edge system clock
//   reset              in   asynchronous active-high, returns to FETCH_HI
//   ir_out[15:0]       in   instruction: [15:12] op, [11:10] rd, [9:8] rs/cond, [7:4] ALU op
//   latch_flags[2:0]   in   ALU flags, bit0 Z, bit1 C, bit2 N
//   pc_inc/pc_load     out  PC increment / load from JR
//   reg_load/reg_enable out register write from bus / register drive onto bus
//   reg_*_regselect    out  write, bus-drive and ALU-operand register selects
//   alu_operation[3:0] out  ALU function code
//   latch_grab/latch_store out capture ALU result+flags / drive result onto bus
//   mar_*/ir_*/jr_*    out  byte loads from the databus
//   mem_read/mem_write out  memory strobes
//   addr_sel           out  address mux: 0 = PC, 1 = MAR
//   halted             out  high while in HALT
import cpu_pkg::*;

module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir_out,
  input  logic [2:0]  latch_flags,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_load,
  output logic        reg_enable,
  output logic [1:0]  reg_in_regselect,
  output logic [1:0]  reg_out_regselect,
  output logic [1:0]  reg_alu_regselect,
  output logic [3:0]  alu_operation,
  output logic        latch_grab,
  output logic        latch_store,
  output logic        mar_high,
  output logic        mar_low,
  output logic        ir_high,
  output logic        ir_low,
  output logic        jr_high,
  output logic        jr_low,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        halted
);

  state_t     state_q;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;
  logic [3:0] opcode;

  // ir_out is stable from DECODE until the next FETCH_HI, so the opcode
  // can be reused for the ADDR_LO branch without a private copy.
  assign opcode = ir_out[15:12];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH_HI;
    end else begin
      case (state_q)
        S_FETCH_HI: state_q <= S_FETCH_LO;
        S_FETCH_LO: state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_NOP:                state_q <= S_FETCH_HI;
            OP_ALU:                state_q <= S_ALU_EX;
            OP_MOV:                state_q <= S_MOV_EX;
            OP_LD, OP_ST, OP_JCC:  state_q <= S_ADDR_HI;
            OP_HLT:                state_q <= S_HALT;
            default:               state_q <= S_FETCH_HI;  // unassigned opcodes act as NOP
          endcase
        end
        S_ALU_EX:  state_q <= S_ALU_WB;
        S_ALU_WB:  state_q <= S_FETCH_HI;
        S_MOV_EX:  state_q <= S_FETCH_HI;
        S_ADDR_HI: state_q <= S_ADDR_LO;
        S_ADDR_LO: begin
          case (opcode)
            OP_LD:   state_q <= S_MEM_RD;
            OP_ST:   state_q <= S_MEM_WR;
            OP_JCC:  state_q <= S_JMP_EX;
            default: state_q <= S_FETCH_HI;
          endcase
        end
        S_MEM_RD:  state_q <= S_FETCH_HI;
        S_MEM_WR:  state_q <= S_FETCH_HI;
        S_JMP_EX:  state_q <= S_FETCH_HI;
        S_HALT:    state_q <= S_HALT;  // only reset leaves HALT
        default:   state_q <= S_FETCH_HI;
      endcase
    end
  end

  cu_decode u_decode (
    .state       (state_q),
    .ir_out      (ir_out),
    .latch_flags (latch_flags),
    .ctrl        (ctrl_raw)
  );

  // state_q sits at FETCH_HI during reset, which would otherwise decode
  // fetch strobes; gate everything so reset is silent, halted included.
  assign ctrl = reset ? '0 : ctrl_raw;

  assign pc_inc            = ctrl.pc_inc;
  assign pc_load           = ctrl.pc_load;
  assign reg_load          = ctrl.reg_load;
  assign reg_enable        = ctrl.reg_enable;
  assign reg_in_regselect  = ctrl.reg_in_regselect;
  assign reg_out_regselect = ctrl.reg_out_regselect;
  assign reg_alu_regselect = ctrl.reg_alu_regselect;
  assign alu_operation     = ctrl.alu_operation;
  assign latch_grab        = ctrl.latch_grab;
  assign latch_store       = ctrl.latch_store;
  assign mar_high          = ctrl.mar_high;
  assign mar_low           = ctrl.mar_low;
  assign ir_high           = ctrl.ir_high;
  assign ir_low            = ctrl.ir_low;
  assign jr_high           = ctrl.jr_high;
  assign jr_low            = ctrl.jr_low;
  assign mem_read          = ctrl.mem_read;
  assign mem_write         = ctrl.mem_write;
  assign addr_sel          = ctrl.addr_sel;
  assign halted            = ctrl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: the driver pushes one hand-built expected output
// vector per clock into exp_q; the monitor pops and compares on the falling
// edge. Vector layout (bit): 25 pc_inc, 24 pc_load, 23 reg_load,
// 22 reg_enable, 21:20 in_sel, 19:18 out_sel, 17:16 alu_sel, 15:12 alu_op,
// 11 latch_grab, 10 latch_store, 9 mar_high, 8 mar_low, 7 ir_high,
// 6 ir_low, 5 jr_high, 4 jr_low, 3 mem_read, 2 mem_write, 1 addr_sel, 0 halted.
module tb_control_unit;

  localparam int W = 26;

  localparam logic [W-1:0] B_PC_INC   = 26'h1 << 25;
  localparam logic [W-1:0] B_PC_LOAD  = 26'h1 << 24;
  localparam logic [W-1:0] B_REG_LOAD = 26'h1 << 23;
  localparam logic [W-1:0] B_REG_EN   = 26'h1 << 22;
  localparam logic [W-1:0] B_GRAB     = 26'h1 << 11;
  localparam logic [W-1:0] B_STORE    = 26'h1 << 10;
  localparam logic [W-1:0] B_MAR_HI   = 26'h1 << 9;
  localparam logic [W-1:0] B_MAR_LO   = 26'h1 << 8;
  localparam logic [W-1:0] B_IR_HI    = 26'h1 << 7;
  localparam logic [W-1:0] B_IR_LO    = 26'h1 << 6;
  localparam logic [W-1:0] B_JR_HI    = 26'h1 << 5;
  localparam logic [W-1:0] B_JR_LO    = 26'h1 << 4;
  localparam logic [W-1:0] B_MEM_RD   = 26'h1 << 3;
  localparam logic [W-1:0] B_MEM_WR   = 26'h1 << 2;
  localparam logic [W-1:0] B_ADDR_SEL = 26'h1 << 1;
  localparam logic [W-1:0] B_HALTED   = 26'h1;

  localparam logic [W-1:0] E_FETCH_HI = B_PC_INC | B_MEM_RD | B_IR_HI;
  localparam logic [W-1:0] E_FETCH_LO = B_PC_INC | B_MEM_RD | B_IR_LO;
  localparam logic [W-1:0] E_ZERO     = '0;

  function automatic logic [W-1:0] in_sel(input logic [1:0] v);
    return W'(v) << 20;
  endfunction
  function automatic logic [W-1:0] out_sel(input logic [1:0] v);
    return W'(v) << 18;
  endfunction
  function automatic logic [W-1:0] alu_sel(input logic [1:0] v);
    return W'(v) << 16;
  endfunction
  function automatic logic [W-1:0] alu_op(input logic [3:0] v);
    return W'(v) << 12;
  endfunction

  logic        clock;
  logic        reset;
  logic [15:0] ir_out;
  logic [2:0]  latch_flags;
  logic        pc_inc, pc_load, reg_load, reg_enable;
  logic [1:0]  reg_in_regselect, reg_out_regselect, reg_alu_regselect;
  logic [3:0]  alu_operation;
  logic        latch_grab, latch_store;
  logic        mar_high, mar_low, ir_high, ir_low, jr_high, jr_low;
  logic        mem_read, mem_write, addr_sel, halted;

  logic [W-1:0] act;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           pcq[$];
  logic [W-1:0] exp_v;
  string        tag_v;
  int           pc_exp;
  int           pc_inc_cnt;
  int           n_checks;
  int           n_fail;

  control_unit dut (
    .clock             (clock),
    .reset             (reset),
    .ir_out            (ir_out),
    .latch_flags       (latch_flags),
    .pc_inc            (pc_inc),
    .pc_load           (pc_load),
    .reg_load          (reg_load),
    .reg_enable        (reg_enable),
    .reg_in_regselect  (reg_in_regselect),
    .reg_out_regselect (reg_out_regselect),
    .reg_alu_regselect (reg_alu_regselect),
    .alu_operation     (alu_operation),
    .latch_grab        (latch_grab),
    .latch_store       (latch_store),
    .mar_high          (mar_high),
    .mar_low           (mar_low),
    .ir_high           (ir_high),
    .ir_low            (ir_low),
    .jr_high           (jr_high),
    .jr_low            (jr_low),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .addr_sel          (addr_sel),
    .halted            (halted)
  );

  assign act = {pc_inc, pc_load, reg_load, reg_enable, reg_in_regselect,
                reg_out_regselect, reg_alu_regselect, alu_operation,
                latch_grab, latch_store, mar_high, mar_low, ir_high, ir_low,
                jr_high, jr_low, mem_read, mem_write, addr_sel, halted};

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- monitor / scoreboard ----------------
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    pc_inc_cnt = 0;
  end

  always @(negedge clock) begin
    // Bus exclusion holds in every sampled cycle, directed or random.
    n_checks++;
    if ((mem_read && mem_write) || ($countones({mem_read, reg_enable, latch_store}) > 1)) begin
      n_fail++;
      $display("FAIL bus_exclusion @%0t: mem_read=%b mem_write=%b reg_enable=%b latch_store=%b required at most one driver",
               $time, mem_read, mem_write, reg_enable, latch_store);
    end
    // pc_inc total for the instruction that just finished.
    if (pcq.size() > 0) begin
      pc_exp = pcq.pop_front();
      n_checks++;
      if (pc_inc_cnt != pc_exp) begin
        n_fail++;
        $display("FAIL pc_inc_total: got %0d required %0d", pc_inc_cnt, pc_exp);
      end
    end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag_v = tag_q.pop_front();
      if (tag_v == "fetch_hi") pc_inc_cnt = 0;
      if (pc_inc) pc_inc_cnt++;
      n_checks++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL %s @%0t: got %07h required %07h", tag_v, $time, act, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: queue this cycle's expectation and
  // advance to just after the next rising edge.
  task automatic step(input logic [W-1:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ir, input logic [2:0] fl);
    ir_out      = ir;
    latch_flags = fl;
    step(E_FETCH_HI, "fetch_hi");
    step(E_FETCH_LO, "fetch_lo");
    step(E_ZERO, "decode");
  endtask

  // Pulse reset mid-cycle: outputs must be zero at once, and because the
  // reset is released before the next edge, only an asynchronous reset
  // leaves the FSM in FETCH_HI so that the following cycle is FETCH_LO.
  task automatic mid_cycle_reset(input string t);
    reset = 1'b1;
    exp_q.push_back(E_ZERO);
    tag_q.push_back(t);
    @(negedge clock);
    #1;
    reset  = 1'b0;
    ir_out = 16'h0000;
    @(posedge clock);
    #1;
    step(E_FETCH_LO, "restart_fetch_lo");
    step(E_ZERO, "restart_decode");
  endtask

  task automatic jcc(input logic [15:0] ir, input logic [2:0] fl, input logic taken, input string t);
    fetch(ir, fl);
    step(B_MEM_RD | B_PC_INC | B_JR_HI, "jr_high");
    step(B_MEM_RD | B_PC_INC | B_JR_LO, "jr_low");
    step(taken ? B_PC_LOAD : E_ZERO, t);
    pcq.push_back(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    ir_out      = 16'h0000;
    latch_flags = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    exp_q.push_back(E_ZERO);
    tag_q.push_back("in_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // NOP: pc_inc in cycles 1-2, next FETCH_HI in cycle 4.
    fetch(16'h0000, 3'b000);
    pcq.push_back(2);

    // ALU rd=1 rs=2 op=3
    fetch(16'h1630, 3'b000);
    step(alu_op(4'd3) | alu_sel(2'd2) | B_GRAB, "alu_ex");
    step(B_STORE | B_REG_LOAD | in_sel(2'd1), "alu_wb");

    // MOV rd=2 rs=3
    fetch(16'h2B00, 3'b000);
    step(B_REG_EN | out_sel(2'd3) | B_REG_LOAD | in_sel(2'd2), "mov_ex");

    // LD rd=3
    fetch(16'h3C00, 3'b000);
    step(B_MEM_RD | B_PC_INC | B_MAR_HI, "mar_high");
    step(B_MEM_RD | B_PC_INC | B_MAR_LO, "mar_low");
    step(B_ADDR_SEL | B_MEM_RD | B_REG_LOAD | in_sel(2'd3), "mem_rd");

    // ST rd=2 rs=1
    fetch(16'h4900, 3'b000);
    step(B_MEM_RD | B_PC_INC | B_MAR_HI, "mar_high");
    step(B_MEM_RD | B_PC_INC | B_MAR_LO, "mar_low");
    step(B_ADDR_SEL | B_MEM_WR | B_REG_EN | out_sel(2'd1), "mem_wr");

    // Jumps over every condition, taken and not taken.
    jcc(16'h5000, 3'b001, 1'b1, "jcc_z_taken");
    jcc(16'h5000, 3'b000, 1'b0, "jcc_z_not_taken");
    jcc(16'h5100, 3'b010, 1'b1, "jcc_c_taken");
    jcc(16'h5100, 3'b101, 1'b0, "jcc_c_not_taken");
    jcc(16'h5200, 3'b011, 1'b0, "jcc_n_not_taken");
    jcc(16'h5200, 3'b100, 1'b1, "jcc_n_taken");
    jcc(16'h5300, 3'b000, 1'b1, "jcc_always");

    // Unassigned opcodes behave as NOP.
    fetch(16'h6000, 3'b111);
    fetch(16'hF000, 3'b000);
    fetch(16'h8FF0, 3'b000);

    // Reset in the middle of ALU_EX.
    fetch(16'h1630, 3'b000);
    mid_cycle_reset("reset_in_alu_ex");
    fetch(16'h0000, 3'b000);

    // HLT: halted from cycle 4 and held; reset clears it.
    fetch(16'h7000, 3'b000);
    for (int i = 0; i < 100; i++) step(B_HALTED, "halted_hold");
    ir_out = 16'h0000;
    mid_cycle_reset("reset_in_halt");
    fetch(16'h0000, 3'b000);

    // Random opcode stream for the bus-exclusion check.
    for (int i = 0; i < 400; i++) begin
      if (halted) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      ir_out      = 16'($urandom_range(0, 16'hFFFF));
      latch_flags = 3'($urandom_range(0, 7));
      @(posedge clock);
      #1;
    end

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
